// File: rtl/l15_req_master.sv
`timescale 1ns/1ps
// Single-outstanding L1.5 transducer request master: one core load/store at a time,
// every L1.5 return acked, watchdog abandons requests that never get their return.
module l15_req_master #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic        req_nc,
  input  logic [2:0]  req_size,
  input  logic [39:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        resp_timeout,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic [63:0] transducer_l15_data_next_entry,
  output logic [0:0]  transducer_l15_threadid,
  output logic [3:0]  transducer_l15_amo_op,
  output logic        transducer_l15_prefetch,
  output logic        transducer_l15_invalidate_cacheline,
  output logic        transducer_l15_blockstore,
  output logic        transducer_l15_blockinitstore,
  output logic [1:0]  transducer_l15_l1rplway,
  output logic [32:0] transducer_l15_csm_data,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [1:0]  l15_transducer_error,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wdog;
  logic [CW-1:0] wdog_next;
  logic          expired;
  logic          is_store;
  logic          ret_match;

  assign transducer_l15_data_next_entry      = '0;
  assign transducer_l15_threadid             = '0;
  assign transducer_l15_amo_op               = '0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = '0;
  assign transducer_l15_csm_data             = '0;

  // Every return is acked the cycle it appears, whether or not it is consumed.
  assign transducer_l15_req_ack = l15_transducer_val;

  assign is_store  = transducer_l15_rqtype[0];
  assign wdog_next = wdog + 1'b1;
  assign expired   = (wdog_next == CW'(TIMEOUT_CYCLES));
  assign ret_match = l15_transducer_val &&
                     (l15_transducer_returntype == (is_store ? 4'b0100 : 4'b0000));

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      wdog                   <= '0;
      req_rdy                <= 1'b1;
      resp_val               <= 1'b0;
      resp_rdata             <= '0;
      resp_err               <= '0;
      resp_timeout           <= 1'b0;
      transducer_l15_val     <= 1'b0;
      transducer_l15_rqtype  <= '0;
      transducer_l15_nc      <= 1'b0;
      transducer_l15_size    <= '0;
      transducer_l15_address <= '0;
      transducer_l15_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            transducer_l15_rqtype  <= {4'b0000, req_we};
            transducer_l15_nc      <= req_nc;
            transducer_l15_size    <= req_size;
            transducer_l15_address <= req_addr;
            transducer_l15_data    <= req_wdata;
            transducer_l15_val     <= 1'b1;
            req_rdy                <= 1'b0;
            wdog                   <= '0;
            state                  <= REQ;
          end
        end
        REQ: begin
          wdog <= wdog_next;
          if (expired) begin
            transducer_l15_val <= 1'b0;
            resp_val           <= 1'b1;
            resp_timeout       <= 1'b1;
            resp_rdata         <= '0;
            resp_err           <= '0;
            state              <= RESP;
          end else if (l15_transducer_ack) begin
            transducer_l15_val <= 1'b0;
            state              <= WAIT;
          end
        end
        WAIT: begin
          wdog <= wdog_next;
          // A matching return on the expiry cycle still wins over the watchdog.
          if (ret_match) begin
            resp_val     <= 1'b1;
            resp_timeout <= 1'b0;
            resp_err     <= l15_transducer_error;
            if (is_store)
              resp_rdata <= '0;
            else
              resp_rdata <= transducer_l15_address[3] ? l15_transducer_data_1
                                                      : l15_transducer_data_0;
            state <= RESP;
          end else if (expired) begin
            resp_val     <= 1'b1;
            resp_timeout <= 1'b1;
            resp_rdata   <= '0;
            resp_err     <= '0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= '0;
            req_rdy      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_req_master.sv
`timescale 1ns/1ps
// Bench for l15_req_master: the bench plays both the core and the L1.5, and predicts
// each response from the request, the ack/return delays and the watchdog budget.
module tb_l15_req_master;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0, req_we = 1'b0, req_nc = 1'b0;
  logic [2:0]  req_size = '0;
  logic [39:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_rdy = 1'b0;
  logic        l15_ack = 1'b0, l15_hdr_ack = 1'b0, l15_val = 1'b0;
  logic [3:0]  l15_rt = '0;
  logic [1:0]  l15_err = '0;
  logic [63:0] l15_d0 = '0, l15_d1 = '0;

  logic        req_rdy, resp_val, resp_timeout, tval, req_ack;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [4:0]  rqtype;
  logic        t_nc;
  logic [2:0]  t_size;
  logic [39:0] t_addr;
  logic [63:0] t_data, t_dne;
  logic [0:0]  t_tid;
  logic [3:0]  t_amo;
  logic        t_pf, t_inv, t_bs, t_bis;
  logic [1:0]  t_rpl;
  logic [32:0] t_csm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l15_req_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we), .req_nc(req_nc),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .transducer_l15_val(tval), .transducer_l15_rqtype(rqtype),
    .transducer_l15_nc(t_nc), .transducer_l15_size(t_size),
    .transducer_l15_address(t_addr), .transducer_l15_data(t_data),
    .transducer_l15_data_next_entry(t_dne), .transducer_l15_threadid(t_tid),
    .transducer_l15_amo_op(t_amo), .transducer_l15_prefetch(t_pf),
    .transducer_l15_invalidate_cacheline(t_inv), .transducer_l15_blockstore(t_bs),
    .transducer_l15_blockinitstore(t_bis), .transducer_l15_l1rplway(t_rpl),
    .transducer_l15_csm_data(t_csm),
    .l15_transducer_ack(l15_ack), .l15_transducer_header_ack(l15_hdr_ack),
    .l15_transducer_val(l15_val), .l15_transducer_returntype(l15_rt),
    .l15_transducer_error(l15_err), .l15_transducer_data_0(l15_d0),
    .l15_transducer_data_1(l15_d1), .transducer_l15_req_ack(req_ack)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_rdy got %b want 1", req_rdy); end
    tests++;
    if ({resp_val, resp_timeout, tval, req_ack} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctl got %b want 0000", {resp_val, resp_timeout, tval, req_ack});
    end
    tests++;
    if ({resp_rdata, resp_err, rqtype, t_nc, t_size, t_addr, t_data} !== '0) begin
      fails++; $display("FAIL reset_fields got rdata=%h addr=%h data=%h want 0", resp_rdata, t_addr, t_data);
    end
    tests++;
    if ({t_dne, t_tid, t_amo, t_pf, t_inv, t_bs, t_bis, t_rpl, t_csm} !== '0) begin
      fails++; $display("FAIL reset_consts got nonzero want 0");
    end
  endtask

  // One full transaction: ack after a cycles of val, matching return after r
  // idle/junk WAIT cycles, response held for 'hold' cycles before resp_rdy.
  task automatic run_txn(input bit we, input logic [39:0] addr, input logic [63:0] wdata,
                         input int a, input int r, input bit inv_junk,
                         input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] err,
                         input int hold, input string name);
    logic [3:0]  exp_rt, jrt;
    logic [63:0] exp_data;
    logic [1:0]  exp_err;
    logic        nc;
    logic [2:0]  size;
    bit          exp_to, matched;
    exp_rt   = we ? 4'b0100 : 4'b0000;
    exp_to   = (a + r + 2) > T;
    exp_data = (exp_to || we) ? 64'h0 : (addr[3] ? d1 : d0);
    exp_err  = exp_to ? 2'b00 : err;
    nc       = 1'($urandom);
    size     = 3'($urandom);

    @(negedge clk);
    tests++;
    if (req_rdy !== 1'b1) begin fails++; $display("FAIL %s req_rdy_idle got %b want 1", name, req_rdy); end
    req_val = 1'b1; req_we = we; req_nc = nc; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0; req_we = ~we; req_nc = ~nc; req_addr = ~addr; req_wdata = ~wdata;
    tests++;
    if ({tval, req_rdy, rqtype} !== {2'b10, 4'b0000, we}) begin
      fails++; $display("FAIL %s req_issue got val/rdy/rqtype=%b want %b", name, {tval, req_rdy, rqtype}, {2'b10, 4'b0000, we});
    end
    tests++;
    if ({t_nc, t_size, t_addr, t_data} !== {nc, size, addr, wdata}) begin
      fails++; $display("FAIL %s req_fields got addr=%h data=%h want addr=%h data=%h", name, t_addr, t_data, addr, wdata);
    end
    for (int i = 0; i < a; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if ({tval, resp_val} !== 2'b10) begin
        fails++; $display("FAIL %s req_hold got val/resp_val=%b want 10", name, {tval, resp_val});
      end
    end
    l15_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l15_ack = 1'b0;
    tests++;
    if ({tval, resp_val} !== 2'b00) begin
      fails++; $display("FAIL %s after_ack got val/resp_val=%b want 00", name, {tval, resp_val});
    end

    matched = 1'b0;
    for (int c = a + 2; c <= T && !matched; c++) begin
      if (c == a + r + 2) begin
        l15_val = 1'b1; l15_rt = exp_rt; l15_d0 = d0; l15_d1 = d1; l15_err = err;
        matched = 1'b1;
      end else if (inv_junk || $urandom_range(0, 1) == 1) begin
        jrt = 4'b0011;
        if (!inv_junk) begin
          jrt = 4'($urandom);
          if (jrt == exp_rt) jrt = exp_rt ^ 4'b0100;
        end
        l15_val = 1'b1; l15_rt = jrt; l15_d0 = {$urandom, $urandom};
        l15_d1 = {$urandom, $urandom}; l15_err = 2'($urandom);
      end else begin
        l15_val = 1'b0;
      end
      #1;
      tests++;
      if (req_ack !== l15_val) begin
        fails++; $display("FAIL %s wait_req_ack got %b want %b", name, req_ack, l15_val);
      end
      @(posedge clk);
      @(negedge clk);
      l15_val = 1'b0;
      if (!matched && c < T) begin
        tests++;
        if (resp_val !== 1'b0) begin fails++; $display("FAIL %s early_resp got %b want 0", name, resp_val); end
      end
    end

    tests++;
    if ({resp_val, resp_timeout, tval, req_ack, req_rdy} !== {1'b1, exp_to, 3'b000}) begin
      fails++; $display("FAIL %s resp_ctl got val/to/tval/ack/rdy=%b want %b", name,
                        {resp_val, resp_timeout, tval, req_ack, req_rdy}, {1'b1, exp_to, 3'b000});
    end
    tests++;
    if ({resp_rdata, resp_err} !== {exp_data, exp_err}) begin
      fails++; $display("FAIL %s resp_data got rdata=%h err=%b want rdata=%h err=%b", name, resp_rdata, resp_err, exp_data, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      if (exp_to && h == 0) begin
        l15_val = 1'b1; l15_rt = exp_rt; l15_d0 = d0 ^ 64'h5; l15_d1 = d1 ^ 64'h5; l15_err = 2'b11;
        #1;
        tests++;
        if (req_ack !== 1'b1) begin fails++; $display("FAIL %s late_ack_resp got %b want 1", name, req_ack); end
      end
      @(posedge clk);
      @(negedge clk);
      l15_val = 1'b0;
      tests++;
      if ({resp_val, resp_timeout, req_rdy, resp_rdata, resp_err} !== {1'b1, exp_to, 1'b0, exp_data, exp_err}) begin
        fails++; $display("FAIL %s resp_stable got val=%b to=%b rdy=%b rdata=%h want val=1 to=%b rdy=0 rdata=%h",
                          name, resp_val, resp_timeout, req_rdy, resp_rdata, exp_to, exp_data);
      end
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    tests++;
    if ({resp_val, req_rdy} !== 2'b01) begin
      fails++; $display("FAIL %s resp_done got val/rdy=%b want 01", name, {resp_val, req_rdy});
    end
    if (exp_to) begin
      l15_val = 1'b1; l15_rt = exp_rt;
      #1;
      tests++;
      if (req_ack !== 1'b1) begin fails++; $display("FAIL %s late_ack_idle got %b want 1", name, req_ack); end
      @(posedge clk);
      @(negedge clk);
      l15_val = 1'b0;
      tests++;
      if ({resp_val, req_rdy} !== 2'b01) begin
        fails++; $display("FAIL %s late_drop got val/rdy=%b want 01", name, {resp_val, req_rdy});
      end
    end
  endtask

  task automatic test_load();
    run_txn(1'b0, 40'h00_8000_0008, 64'h0, 2, 0, 1'b0, 64'h1111, 64'h2222, 2'b00, 0, "load");
  endtask

  task automatic test_store();
    run_txn(1'b1, 40'h00_8000_0000, 64'hDEADBEEF, 0, 0, 1'b0, 64'h77, 64'h88, 2'b10, 0, "store");
  endtask

  task automatic test_inval_first();
    run_txn(1'b0, 40'h00_1234_5670, 64'h0, 0, 1, 1'b1, 64'hAAAA_0000_0000_0001, 64'hBBBB, 2'b01, 1, "inval_first");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 40'h00_8000_0010, 64'h0, 0, T + 4, 1'b0, 64'h1, 64'h2, 2'b01, 2, "timeout");
    run_txn(1'b0, 40'h00_8000_0018, 64'h0, 1, 1, 1'b0, 64'h3, 64'h4, 2'b00, 0, "after_timeout");
  endtask

  task automatic test_resp_hold();
    run_txn(1'b0, 40'h00_0000_0100, 64'h0, 1, 2, 1'b0, 64'hCAFE_F00D, 64'h9, 2'b11, 5, "resp_hold");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_val = 1'b1; req_we = 1'b0; req_addr = 40'h00_0000_0040;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0; l15_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l15_ack = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({req_rdy, tval, resp_val} !== 3'b100) begin
      fails++; $display("FAIL rst_mid_state got rdy/val/resp=%b want 100", {req_rdy, tval, resp_val});
    end
    l15_val = 1'b1; l15_rt = 4'b0000; l15_d0 = 64'h55;
    #1;
    tests++;
    if (req_ack !== 1'b1) begin fails++; $display("FAIL rst_mid_ack got %b want 1", req_ack); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      l15_val = 1'b0;
      tests++;
      if ({resp_val, req_rdy} !== 2'b01) begin
        fails++; $display("FAIL rst_mid_drop got val/rdy=%b want 01", {resp_val, req_rdy});
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), {8'($urandom), 32'($urandom)}, {$urandom, $urandom},
              $urandom_range(0, 5), $urandom_range(0, 16), 1'b0,
              {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
              $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_inval_first();
    test_timeout();
    test_reset_mid();
    test_resp_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
